// File: rtl/spike_aer_arbiter_pkg.sv
// Shared SNN constants and the AER event record used by the spike arbiter
// and its neighbours in the neuron array.
package snn_pkg;

  localparam int N_DEF        = 8;
  localparam int TW_DEF       = 16;
  localparam int T_WINDOW_DEF = 250;
  localparam int AW_DEF       = $clog2(N_DEF);

  // Membrane potential width, shared with the neuron datapath.
  localparam int POT_W = 24;

  // One address event; 'time' is a keyword, so the stamp is called tstamp.
  typedef struct packed {
    logic [AW_DEF-1:0] addr;
    logic [TW_DEF-1:0] tstamp;
  } aer_event_t;

endpackage

// File: rtl/spike_aer_arbiter_if.sv
// Valid/ready address-event stream between the arbiter (master) and the
// downstream spike consumer (slave).
interface spike_aer_arbiter_if #(
  parameter int AW = snn_pkg::AW_DEF,
  parameter int TW = snn_pkg::TW_DEF
) ();

  logic          ev_valid;
  logic          ev_ready;
  logic [AW-1:0] ev_addr;
  logic [TW-1:0] ev_time;

  modport master (output ev_valid, output ev_addr, output ev_time, input ev_ready);
  modport slave  (input ev_valid, input ev_addr, input ev_time, output ev_ready);

endinterface

// File: rtl/spike_aer_arbiter_rr_pick.sv
// Combinational rotate-priority pick: first set request at or above ptr,
// wrapping past N-1 back to 0.
module spike_rr_pick
  import snn_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int AW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [AW-1:0] ptr,
  output logic [AW-1:0] gnt_idx,
  output logic          gnt_any
);

  // Neuron index examined at each search offset from ptr.
  logic [AW-1:0] idx [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_idx
      assign idx[gi] = AW'((int'(ptr) + gi) % N);
    end
  endgenerate

  // Scan from the farthest offset down so the nearest request wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[idx[k]]) begin
        gnt_any = 1'b1;
        gnt_idx = idx[k];
      end
    end
  end

endmodule

// File: rtl/spike_aer_arbiter.sv
// Round-robin spike-to-AER serializer with timestep counter and drop count.
// Optional winner-take-all inhibit output enabled by macro SPIKE_AER_WTA_EN.
module spike_aer_arbiter
  import snn_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int AW       = $clog2(N),
  parameter int TW       = TW_DEF,
  parameter int T_WINDOW = T_WINDOW_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [N-1:0]        spike_in,
  spike_aer_arbiter_if.master ev,
  output logic [N-1:0]        inh_out,
  output logic                window_done,
  output logic [15:0]         drop_cnt
);

  logic [N-1:0]  pend_reg, pend_next, clr_vec, drop_vec;
  logic [AW-1:0] ptr_reg, ptr_next, gnt_idx;
  logic          gnt_any, slot_free, load, t_wrap;
  logic          ev_valid_reg;
  logic [AW-1:0] ev_addr_reg;
  logic [TW-1:0] ev_time_reg, t_cnt_reg;
  logic          window_done_reg;
  logic [15:0]   drop_cnt_reg, drop_cnt_next;
  logic [16:0]   drop_sum;

  spike_rr_pick #(.N(N), .AW(AW)) u_pick (
    .req     (pend_reg),
    .ptr     (ptr_reg),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign slot_free = ~ev_valid_reg | ev.ev_ready;
  assign load      = en & slot_free & gnt_any;
  assign t_wrap    = (t_cnt_reg == TW'(T_WINDOW - 1));

  // A new spike on the clearing edge wins over the clear, so it is not a drop.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_bits
      assign clr_vec[gi]  = load & (gnt_idx == AW'(gi));
      assign drop_vec[gi] = en & spike_in[gi] & pend_reg[gi] & ~clr_vec[gi];
    end
  endgenerate

  assign pend_next = en ? ((pend_reg & ~clr_vec) | spike_in) : pend_reg;
  assign ptr_next  = load ? ((gnt_idx == AW'(N - 1)) ? '0 : gnt_idx + AW'(1)) : ptr_reg;

  // Add all drops of this edge to the counter, clamping at all-ones.
  always_comb begin
    drop_sum = {1'b0, drop_cnt_reg};
    for (int i = 0; i < N; i++) begin
      drop_sum = drop_sum + {16'd0, drop_vec[i]};
    end
    drop_cnt_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  // Pending bits, rotate pointer and drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_reg     <= '0;
      ptr_reg      <= '0;
      drop_cnt_reg <= '0;
    end else begin
      pend_reg     <= pend_next;
      ptr_reg      <= ptr_next;
      drop_cnt_reg <= drop_cnt_next;
    end
  end

  // Event slot: load takes priority, otherwise a handshake empties it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ev_valid_reg <= 1'b0;
      ev_addr_reg  <= '0;
      ev_time_reg  <= '0;
    end else if (load) begin
      ev_valid_reg <= 1'b1;
      ev_addr_reg  <= gnt_idx;
      ev_time_reg  <= t_cnt_reg;
    end else if (ev_valid_reg & ev.ev_ready) begin
      ev_valid_reg <= 1'b0;
    end
  end

  // Timestep counter with a one-cycle pulse after each window wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      t_cnt_reg       <= '0;
      window_done_reg <= 1'b0;
    end else begin
      if (en) begin
        t_cnt_reg <= t_wrap ? '0 : t_cnt_reg + TW'(1);
      end
      window_done_reg <= en & t_wrap;
    end
  end

`ifdef SPIKE_AER_WTA_EN
  logic [N-1:0] inh_reg;

  // Inhibit every neuron except the winner for the cycle after a load.
  always_ff @(posedge clk) begin
    if (rst) begin
      inh_reg <= '0;
    end else begin
      inh_reg <= load ? ~clr_vec : '0;
    end
  end

  assign inh_out = inh_reg;
`else
  assign inh_out = '0;
`endif

  assign ev.ev_valid = ev_valid_reg;
  assign ev.ev_addr  = ev_addr_reg;
  assign ev.ev_time  = ev_time_reg;
  assign window_done = window_done_reg;
  assign drop_cnt    = drop_cnt_reg;

endmodule

// File: tb/tb_spike_aer_arbiter.sv
// Directed bench for spike_aer_arbiter: a default-window instance for the
// event path and a T_WINDOW=4 instance for the window pulse.
module tb_spike_aer_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       en_w = 1'b0;
  logic [7:0] spike_in = 8'h00;
  logic [7:0] spike_w = 8'h00;
  logic [7:0] inh_out, inh_w;
  logic       window_done, wd_w;
  logic [15:0] drop_cnt, drop_w;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_exp;

`ifdef SPIKE_AER_WTA_EN
  localparam bit WTA = 1'b1;
`else
  localparam bit WTA = 1'b0;
`endif

  spike_aer_arbiter_if #(.AW(3), .TW(16)) ev_if ();
  spike_aer_arbiter_if #(.AW(3), .TW(16)) ev_w_if ();

  spike_aer_arbiter #(.N(8), .AW(3), .TW(16), .T_WINDOW(250)) dut (
    .clk(clk), .rst(rst), .en(en), .spike_in(spike_in), .ev(ev_if),
    .inh_out(inh_out), .window_done(window_done), .drop_cnt(drop_cnt)
  );

  spike_aer_arbiter #(.N(8), .AW(3), .TW(16), .T_WINDOW(4)) dut_w (
    .clk(clk), .rst(rst), .en(en_w), .spike_in(spike_w), .ev(ev_w_if),
    .inh_out(inh_w), .window_done(wd_w), .drop_cnt(drop_w)
  );

  always #5 clk = ~clk;

  // One line per accepted event.
  always @(posedge clk) begin
    if (!rst && ev_if.ev_valid && ev_if.ev_ready)
      $display("event addr=%0d time=%0d", ev_if.ev_addr, ev_if.ev_time);
  end

  function automatic logic [7:0] exp_inh(input int g);
    logic [7:0] one;
    one = 8'h01;
    return WTA ? ~(one << g) : 8'h00;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    spike_in = 8'h00;
    step();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    ev_if.ev_ready = 1'b1;
    ev_w_if.ev_ready = 1'b1;
    en = 1'b1;
    do_reset();
    checks++; if (ev_if.ev_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h want 0", ev_if.ev_valid); end
    checks++; if (ev_if.ev_addr !== 3'd0) begin errors++; $display("FAIL reset_addr got %0h want 0", ev_if.ev_addr); end
    checks++; if (ev_if.ev_time !== 16'd0) begin errors++; $display("FAIL reset_time got %0h want 0", ev_if.ev_time); end
    checks++; if (inh_out !== 8'h00) begin errors++; $display("FAIL reset_inh got %0h want 0", inh_out); end
    checks++; if (window_done !== 1'b0) begin errors++; $display("FAIL reset_wd got %0h want 0", window_done); end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop got %0h want 0", drop_cnt); end
  endtask

  task automatic test_single_spike();
    for (int c = 0; c <= 8; c++) begin
      spike_in = (c == 5) ? 8'h04 : 8'h00;
      if (c == 6) begin
        checks++; if (ev_if.ev_valid !== 1'b0) begin errors++; $display("FAIL single_early got %0h want 0", ev_if.ev_valid); end
      end
      if (c == 7) begin
        checks++; if (ev_if.ev_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0h want 1", ev_if.ev_valid); end
        checks++; if (ev_if.ev_addr !== 3'd2) begin errors++; $display("FAIL single_addr got %0d want 2", ev_if.ev_addr); end
        checks++; if (ev_if.ev_time !== 16'd6) begin errors++; $display("FAIL single_time got %0d want 6", ev_if.ev_time); end
        checks++; if (inh_out !== exp_inh(2)) begin errors++; $display("FAIL single_inh got %0h want %0h", inh_out, exp_inh(2)); end
      end
      if (c == 8) begin
        checks++; if (ev_if.ev_valid !== 1'b0) begin errors++; $display("FAIL single_clear got %0h want 0", ev_if.ev_valid); end
        checks++; if (inh_out !== 8'h00) begin errors++; $display("FAIL single_inh_off got %0h want 0", inh_out); end
      end
      step();
    end
  endtask

  task automatic test_round_robin();
    spike_in = 8'h81;
    step();
    spike_in = 8'h00;
    checks++; if (ev_if.ev_valid !== 1'b0) begin errors++; $display("FAIL rr_idle got %0h want 0", ev_if.ev_valid); end
    step();
    checks++; if (ev_if.ev_valid !== 1'b1 || ev_if.ev_addr !== 3'd7) begin errors++; $display("FAIL rr_first got v=%0h a=%0d want v=1 a=7", ev_if.ev_valid, ev_if.ev_addr); end
    checks++; if (inh_out !== exp_inh(7)) begin errors++; $display("FAIL rr_inh7 got %0h want %0h", inh_out, exp_inh(7)); end
    step();
    checks++; if (ev_if.ev_valid !== 1'b1 || ev_if.ev_addr !== 3'd0) begin errors++; $display("FAIL rr_second got v=%0h a=%0d want v=1 a=0", ev_if.ev_valid, ev_if.ev_addr); end
    checks++; if (inh_out !== exp_inh(0)) begin errors++; $display("FAIL rr_inh0 got %0h want %0h", inh_out, exp_inh(0)); end
    step();
    checks++; if (ev_if.ev_valid !== 1'b0) begin errors++; $display("FAIL rr_done got %0h want 0", ev_if.ev_valid); end
  endtask

  task automatic test_backpressure();
    ev_if.ev_ready = 1'b0;
    spike_in = 8'h0E;
    step();
    spike_in = 8'h00;
    t_exp = cyc;
    step();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (ev_if.ev_valid !== 1'b1 || ev_if.ev_addr !== 3'd1 || ev_if.ev_time !== 16'(t_exp)) begin
        errors++;
        $display("FAIL bp_hold%0d got v=%0h a=%0d t=%0d want v=1 a=1 t=%0d", i, ev_if.ev_valid, ev_if.ev_addr, ev_if.ev_time, t_exp);
      end
      step();
    end
    ev_if.ev_ready = 1'b1;
    checks++; if (ev_if.ev_addr !== 3'd1) begin errors++; $display("FAIL bp_last_hold got %0d want 1", ev_if.ev_addr); end
    t_exp = cyc;
    step();
    checks++; if (ev_if.ev_valid !== 1'b1 || ev_if.ev_addr !== 3'd2 || ev_if.ev_time !== 16'(t_exp)) begin errors++; $display("FAIL bp_drain2 got v=%0h a=%0d t=%0d want v=1 a=2 t=%0d", ev_if.ev_valid, ev_if.ev_addr, ev_if.ev_time, t_exp); end
    t_exp = cyc;
    step();
    checks++; if (ev_if.ev_valid !== 1'b1 || ev_if.ev_addr !== 3'd3 || ev_if.ev_time !== 16'(t_exp)) begin errors++; $display("FAIL bp_drain3 got v=%0h a=%0d t=%0d want v=1 a=3 t=%0d", ev_if.ev_valid, ev_if.ev_addr, ev_if.ev_time, t_exp); end
    step();
    checks++; if (ev_if.ev_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %0h want 0", ev_if.ev_valid); end
  endtask

  task automatic test_drop();
    ev_if.ev_ready = 1'b0;
    spike_in = 8'h40;
    step();
    spike_in = 8'h02;
    step();
    spike_in = 8'h02;
    checks++; if (ev_if.ev_valid !== 1'b1 || ev_if.ev_addr !== 3'd6) begin errors++; $display("FAIL drop_hold got v=%0h a=%0d want v=1 a=6", ev_if.ev_valid, ev_if.ev_addr); end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL drop_none got %0d want 0", drop_cnt); end
    step();
    spike_in = 8'h02;
    ev_if.ev_ready = 1'b1;
    checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL drop_one got %0d want 1", drop_cnt); end
    step();
    spike_in = 8'h00;
    checks++; if (ev_if.ev_valid !== 1'b1 || ev_if.ev_addr !== 3'd1) begin errors++; $display("FAIL drop_ev1 got v=%0h a=%0d want v=1 a=1", ev_if.ev_valid, ev_if.ev_addr); end
    checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL drop_coincide got %0d want 1", drop_cnt); end
    step();
    checks++; if (ev_if.ev_valid !== 1'b1 || ev_if.ev_addr !== 3'd1) begin errors++; $display("FAIL drop_ev1b got v=%0h a=%0d want v=1 a=1", ev_if.ev_valid, ev_if.ev_addr); end
    step();
    checks++; if (ev_if.ev_valid !== 1'b0 || drop_cnt !== 16'd1) begin errors++; $display("FAIL drop_end got v=%0h d=%0d want v=0 d=1", ev_if.ev_valid, drop_cnt); end
  endtask

  task automatic test_reset_mid();
    ev_if.ev_ready = 1'b0;
    spike_in = 8'h30;
    step();
    spike_in = 8'h00;
    step();
    checks++; if (ev_if.ev_valid !== 1'b1 || ev_if.ev_addr !== 3'd4) begin errors++; $display("FAIL mid_pre got v=%0h a=%0d want v=1 a=4", ev_if.ev_valid, ev_if.ev_addr); end
    do_reset();
    checks++; if (ev_if.ev_valid !== 1'b0 || ev_if.ev_addr !== 3'd0 || ev_if.ev_time !== 16'd0) begin errors++; $display("FAIL mid_slot got v=%0h a=%0d t=%0d want 0 0 0", ev_if.ev_valid, ev_if.ev_addr, ev_if.ev_time); end
    checks++; if (inh_out !== 8'h00 || window_done !== 1'b0 || drop_cnt !== 16'd0) begin errors++; $display("FAIL mid_misc got inh=%0h wd=%0h d=%0d want 0 0 0", inh_out, window_done, drop_cnt); end
    ev_if.ev_ready = 1'b1;
    spike_in = 8'h88;
    step();
    spike_in = 8'h00;
    step();
    checks++; if (ev_if.ev_valid !== 1'b1 || ev_if.ev_addr !== 3'd3 || ev_if.ev_time !== 16'd1) begin errors++; $display("FAIL mid_first got v=%0h a=%0d t=%0d want v=1 a=3 t=1", ev_if.ev_valid, ev_if.ev_addr, ev_if.ev_time); end
    step();
    checks++; if (ev_if.ev_valid !== 1'b1 || ev_if.ev_addr !== 3'd7 || ev_if.ev_time !== 16'd2) begin errors++; $display("FAIL mid_second got v=%0h a=%0d t=%0d want v=1 a=7 t=2", ev_if.ev_valid, ev_if.ev_addr, ev_if.ev_time); end
    step();
    checks++; if (ev_if.ev_valid !== 1'b0) begin errors++; $display("FAIL mid_empty got %0h want 0", ev_if.ev_valid); end
  endtask

  task automatic test_window();
    logic exp_wd;
    en_w = 1'b1;
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      exp_wd = (c > 0) && (c % 4 == 0);
      checks++; if (wd_w !== exp_wd) begin errors++; $display("FAIL win_full c=%0d got %0h want %0h", c, wd_w, exp_wd); end
      step();
    end
    do_reset();
    for (int c = 0; c <= 24; c++) begin
      en_w = (c % 2 == 0);
      exp_wd = (c % 8 == 7);
      checks++; if (wd_w !== exp_wd) begin errors++; $display("FAIL win_half c=%0d got %0h want %0h", c, wd_w, exp_wd); end
      step();
    end
    en_w = 1'b0;
  endtask

  initial begin
    ev_if.ev_ready = 1'b1;
    ev_w_if.ev_ready = 1'b1;
    test_reset();
    test_single_spike();
    test_round_robin();
    test_backpressure();
    test_drop();
    test_reset_mid();
    test_window();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
